// File: rtl/CPU_package.sv
// Shared CPU types: data width, ALU opcodes and compare-flag encodings.
// LOGIC_SIGNED_CMP_EN adds signed compare support in logic_unit_core; this package is unaffected.
package CPU_package;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_NOT  = 4'd5,
        ALU_OP_CPR  = 4'd6,
        ALU_OP_SLL  = 4'd7,
        ALU_OP_SRL  = 4'd8,
        ALU_OP_NAND = 4'd9,
        ALU_OP_NOR  = 4'd10,
        ALU_OP_XNOR = 4'd11,
        ALU_OP_CPRS = 4'd12
    } enum_alu_opcode_t;

    localparam logic [2:0] FLAG_EQ = 3'b100;
    localparam logic [2:0] FLAG_GT = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

    // One-hot flag word from the equal / greater-than decisions.
    function automatic logic [2:0] cmp_flags(input logic eq, input logic gt);
        logic [2:0] f;
        if (eq) begin
            f = FLAG_EQ;
        end else if (gt) begin
            f = FLAG_GT;
        end else begin
            f = FLAG_LT;
        end
        return f;
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational logic-op decode between the S1 and S2 registers; 0 cycles, no flow control.
// ALU_OP_CPRS is decoded only when LOGIC_SIGNED_CMP_EN is defined, otherwise it reports op_err.
module logic_unit_core
    import CPU_package::*;
#(
    parameter int WIDTH       = DATA_WIDTH,
    parameter int HOLD_ON_CPR = 1
) (
    input  enum_alu_opcode_t   op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   prev_out,
    input  logic [2:0]         prev_flag,
    output logic [WIDTH-1:0]   res,
    output logic [2:0]         flag,
    output logic               err
);

    logic [WIDTH-1:0] cpr_res;
    logic [2:0]       ucmp_flag;

    assign cpr_res   = (HOLD_ON_CPR != 0) ? prev_out : '0;
    assign ucmp_flag = cmp_flags(a == b, a > b);

`ifdef LOGIC_SIGNED_CMP_EN
    logic [2:0] scmp_flag;
    assign scmp_flag = cmp_flags(a == b, $signed(a) > $signed(b));
`endif

    // Anything not decoded below leaves the previous result and flags in place.
    always_comb begin
        res  = prev_out;
        flag = prev_flag;
        err  = 1'b0;
        case (op)
            ALU_OP_AND:  res = a & b;
            ALU_OP_OR:   res = a | b;
            ALU_OP_XOR:  res = a ^ b;
            ALU_OP_NAND: res = ~(a & b);
            ALU_OP_NOR:  res = ~(a | b);
            ALU_OP_XNOR: res = ~(a ^ b);
            ALU_OP_NOT:  res = ~a;
            ALU_OP_CPR: begin
                res  = cpr_res;
                flag = ucmp_flag;
            end
`ifdef LOGIC_SIGNED_CMP_EN
            ALU_OP_CPRS: begin
                res  = cpr_res;
                flag = scmp_flag;
            end
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage logic unit (S1 operands, S2 result): 2-cycle latency, valid/ready both sides, S1 stalls while S2 is held.
// Define LOGIC_SIGNED_CMP_EN to enable the ALU_OP_CPRS signed compare.
module logic_unit_pipe
    import CPU_package::*;
#(
    parameter int WIDTH       = DATA_WIDTH,
    parameter int HOLD_ON_CPR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  enum_alu_opcode_t alu_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] logic_out,
    output logic [2:0]       logic_out_flag,
    output logic             op_err
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    enum_alu_opcode_t s1_op_q, s1_op_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] logic_out_q, logic_out_d;
    logic [2:0]       flag_q, flag_d;
    logic             op_err_q, op_err_d;

    logic             s1_accept;
    logic             s2_load;
    logic [WIDTH-1:0] core_res;
    logic [2:0]       core_flag;
    logic             core_err;

    logic_unit_core #(
        .WIDTH       (WIDTH),
        .HOLD_ON_CPR (HOLD_ON_CPR)
    ) u_core (
        .op        (s1_op_q),
        .a         (s1_a_q),
        .b         (s1_b_q),
        .prev_out  (logic_out_q),
        .prev_flag (flag_q),
        .res       (core_res),
        .flag      (core_flag),
        .err       (core_err)
    );

    // in_ready covers both an empty S1 and an S1 that moves into S2 this cycle.
    always_comb begin
        s2_load   = s1_valid_q && (!out_valid_q || out_ready);
        in_ready  = !s1_valid_q || !out_valid_q || out_ready;
        s1_accept = in_valid && in_ready;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = alu_opcode;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        logic_out_d = logic_out_q;
        flag_d      = flag_q;
        op_err_d    = op_err_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            logic_out_d = core_res;
            flag_d      = core_flag;
            op_err_d    = core_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= ALU_OP_ADD;
            out_valid_q <= 1'b0;
            logic_out_q <= '0;
            flag_q      <= 3'b000;
            op_err_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            logic_out_q <= logic_out_d;
            flag_q      <= flag_d;
            op_err_q    <= op_err_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign logic_out      = logic_out_q;
    assign logic_out_flag = flag_q;
    assign op_err         = op_err_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed vector table, stall/reset sequences, random traffic.
module tb_logic_unit_pipe;
    import CPU_package::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    enum_alu_opcode_t alu_opcode;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      logic_out;
    logic [2:0]       logic_out_flag;
    logic             op_err;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(16), .HOLD_ON_CPR(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .alu_opcode     (alu_opcode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .logic_out      (logic_out),
        .logic_out_flag (logic_out_flag),
        .op_err         (op_err)
    );

    typedef struct packed {
        logic [15:0] out;
        logic [2:0]  flag;
        logic        err;
    } exp_t;

    typedef struct {
        enum_alu_opcode_t op;
        logic [15:0]      a;
        logic [15:0]      b;
        exp_t             e;
    } vec_t;

`ifdef LOGIC_SIGNED_CMP_EN
    localparam logic [2:0] F_CPRS = 3'b001;
    localparam logic       E_CPRS = 1'b0;
`else
    localparam logic [2:0] F_CPRS = 3'b010;
    localparam logic       E_CPRS = 1'b1;
`endif

    exp_t sb_q[$];
    exp_t m_prev;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rand_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: result word, flags and error for one request given the previous result.
    function automatic exp_t model(input enum_alu_opcode_t op, input logic [15:0] a,
                                   input logic [15:0] b, input exp_t p);
        exp_t r;
        r     = p;
        r.err = 1'b0;
        case (op)
            ALU_OP_AND:  r.out = a & b;
            ALU_OP_OR:   r.out = a | b;
            ALU_OP_XOR:  r.out = a ^ b;
            ALU_OP_NAND: r.out = ~(a & b);
            ALU_OP_NOR:  r.out = ~(a | b);
            ALU_OP_XNOR: r.out = ~(a ^ b);
            ALU_OP_NOT:  r.out = ~a;
            ALU_OP_CPR:  r.flag = (a == b) ? 3'b100 : (a > b) ? 3'b010 : 3'b001;
`ifdef LOGIC_SIGNED_CMP_EN
            ALU_OP_CPRS: r.flag = (a == b) ? 3'b100 :
                                  ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
`endif
            default:     r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Entered and left at posedge+1; pushes the expectation on the edge that accepts.
    task automatic send(input enum_alu_opcode_t op, input logic [15:0] a,
                        input logic [15:0] b, input exp_t e);
        bit done = 1'b0;
        alu_opcode = op;
        in_a       = a;
        in_b       = b;
        in_valid   = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                m_prev = e;
                done   = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready never high, op %0d", op);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb_q.size() != 0; t++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results missing, expected 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every cycle with out_valid is compared, so held outputs are checked for stability too.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_out_valid: got out_valid=1 expected no result at %0t", $time);
            end else begin
                check("logic_out", 32'(logic_out), 32'(sb_q[0].out));
                check("logic_out_flag", 32'(logic_out_flag), 32'(sb_q[0].flag));
                check("op_err", 32'(op_err), 32'(sb_q[0].err));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        vec_t             vec[13];
        exp_t             stall_e[4];
        enum_alu_opcode_t rop;
        logic [15:0]      ra;
        logic [15:0]      rb;

        vec[0]  = '{ALU_OP_AND,  16'hF0F0, 16'hFF00, '{16'hF000, 3'b000, 1'b0}};
        vec[1]  = '{ALU_OP_CPR,  16'h0005, 16'h0003, '{16'hF000, 3'b010, 1'b0}};
        vec[2]  = '{ALU_OP_XOR,  16'h00FF, 16'h0F0F, '{16'h0FF0, 3'b010, 1'b0}};
        vec[3]  = '{ALU_OP_CPR,  16'h8000, 16'h0001, '{16'h0FF0, 3'b010, 1'b0}};
        vec[4]  = '{ALU_OP_CPRS, 16'h8000, 16'h0001, '{16'h0FF0, F_CPRS, E_CPRS}};
        vec[5]  = '{ALU_OP_NOT,  16'h1234, 16'h0000, '{16'hEDCB, F_CPRS, 1'b0}};
        vec[6]  = '{ALU_OP_ADD,  16'h0001, 16'h0001, '{16'hEDCB, F_CPRS, 1'b1}};
        vec[7]  = '{ALU_OP_OR,   16'h0F00, 16'h00F0, '{16'h0FF0, F_CPRS, 1'b0}};
        vec[8]  = '{ALU_OP_NAND, 16'hFFFF, 16'h00FF, '{16'hFF00, F_CPRS, 1'b0}};
        vec[9]  = '{ALU_OP_NOR,  16'h00F0, 16'h0F00, '{16'hF00F, F_CPRS, 1'b0}};
        vec[10] = '{ALU_OP_XNOR, 16'h1234, 16'h1234, '{16'hFFFF, F_CPRS, 1'b0}};
        vec[11] = '{ALU_OP_CPR,  16'h7777, 16'h7777, '{16'hFFFF, 3'b100, 1'b0}};
        vec[12] = '{ALU_OP_CPR,  16'h0001, 16'hFFFF, '{16'hFFFF, 3'b001, 1'b0}};

        stall_e[0] = '{16'h000F, 3'b001, 1'b0};
        stall_e[1] = '{16'h1234, 3'b001, 1'b0};
        stall_e[2] = '{16'h1234, 3'b010, 1'b0};
        stall_e[3] = '{16'hF00F, 3'b010, 1'b0};

        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        alu_opcode = ALU_OP_AND;
        out_ready  = 1'b1;
        m_prev     = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(1'b0));
        check("rst_logic_out", 32'(logic_out), 32'(16'h0000));
        check("rst_flag", 32'(logic_out_flag), 32'(3'b000));
        check("rst_op_err", 32'(op_err), 32'(1'b0));
        check("rst_in_ready", 32'(in_ready), 32'(1'b1));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First request: S1 only after the accept edge, result after the next edge.
        send(vec[0].op, vec[0].a, vec[0].b, vec[0].e);
        check("latency_s1", 32'(out_valid), 32'(1'b0));
        @(posedge clk);
        #1;
        check("latency_s2", 32'(out_valid), 32'(1'b1));
        for (int i = 1; i < 13; i++) send(vec[i].op, vec[i].a, vec[i].b, vec[i].e);
        drain();

        // Four back-to-back requests against a consumer stalled for three cycles.
        out_ready = 1'b0;
        fork
            begin
                send(ALU_OP_AND,  16'h00FF, 16'h0F0F, stall_e[0]);
                send(ALU_OP_OR,   16'h1200, 16'h0034, stall_e[1]);
                send(ALU_OP_CPR,  16'h0030, 16'h0020, stall_e[2]);
                send(ALU_OP_XNOR, 16'hFF00, 16'hF0F0, stall_e[3]);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'(1'b0));
                check("stall_out_valid", 32'(out_valid), 32'(1'b1));
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with one request in S1 and one held in S2.
        out_ready = 1'b0;
        send(ALU_OP_AND, 16'h1111, 16'hFFFF, model(ALU_OP_AND, 16'h1111, 16'hFFFF, m_prev));
        send(ALU_OP_OR,  16'h2222, 16'h0000, model(ALU_OP_OR, 16'h2222, 16'h0000, m_prev));
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(1'b0));
        check("midrst_logic_out", 32'(logic_out), 32'(16'h0000));
        check("midrst_flag", 32'(logic_out_flag), 32'(3'b000));
        check("midrst_op_err", 32'(op_err), 32'(1'b0));
        check("midrst_in_ready", 32'(in_ready), 32'(1'b1));
        sb_q.delete();
        m_prev    = '0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_valid", 32'(out_valid), 32'(1'b0));
        end
        @(posedge clk);
        #1;
        send(ALU_OP_XOR, 16'h0F0F, 16'h00FF, '{16'h0FF0, 3'b000, 1'b0});
        drain();

        // Random traffic with random consumer backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    rop = enum_alu_opcode_t'(4'($urandom_range(0, 12)));
                    ra  = 16'($urandom);
                    rb  = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
                    send(rop, ra, rb, model(rop, ra, rb, m_prev));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
